// File: rtl/usbf_pkt_fifo_if.sv
// Write/read/control bundle between a USB endpoint engine and its packet FIFO.
// The master drives push/pop/commit/rollback/flush; the FIFO (slave) reports data and status.
interface usbf_pkt_fifo_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 6
);
  logic [WIDTH-1:0] data_i;
  logic             push_i;
  logic             commit_i;
  logic             rollback_i;
  logic             pop_i;
  logic             flush_i;
  logic [WIDTH-1:0] data_o;
  logic             empty_o;
  logic             full_o;
  logic             afull_o;
  logic             overflow_o;
  logic [ADDR_W:0]  level_o;
  logic [ADDR_W:0]  pending_o;

  modport master (
    output data_i, push_i, commit_i, rollback_i, pop_i, flush_i,
    input  data_o, empty_o, full_o, afull_o, overflow_o, level_o, pending_o
  );

  modport slave (
    input  data_i, push_i, commit_i, rollback_i, pop_i, flush_i,
    output data_o, empty_o, full_o, afull_o, overflow_o, level_o, pending_o
  );
endinterface

// File: rtl/usbf_pkt_fifo.sv
// Packet FIFO: pushes stay pending until commit, rollback discards them; zero-latency read.
// Pushes while full are dropped and poison the packet (sticky overflow); pops while empty are ignored.
module usbf_pkt_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int AFULL_LEVEL = 56
) (
  input  logic              clk_i,
  input  logic              rst_i,
  usbf_pkt_fifo_if.slave    bus
);
  localparam int CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] wr_cmt_ptr_q, wr_cmt_ptr_d;
  logic [CNT_W-1:0]  cnt_c_q, cnt_c_d;
  logic [CNT_W-1:0]  cnt_t_q, cnt_t_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              full, empty;
  logic              push_ok, pop_ok, push_drop, discard;
  logic [CNT_W-1:0]  push_inc, pop_dec;

  assign full      = (cnt_t_q == CNT_W'(DEPTH));
  assign empty     = (cnt_c_q == '0);
  assign push_ok   = bus.push_i & ~full  & ~bus.flush_i;
  assign pop_ok    = bus.pop_i  & ~empty & ~bus.flush_i;
  assign push_drop = bus.push_i &  full  & ~bus.flush_i;
  // A poisoned packet cannot be published, so its commit degrades to a rollback.
  assign discard   = bus.rollback_i | (bus.commit_i & (ovf_q | push_drop));
  assign push_inc  = CNT_W'(push_ok);
  assign pop_dec   = CNT_W'(pop_ok);

  always_comb begin
    rd_ptr_d     = rd_ptr_q + ADDR_W'(pop_ok);
    wr_ptr_d     = wr_ptr_q + ADDR_W'(push_ok);
    wr_cmt_ptr_d = wr_cmt_ptr_q;
    cnt_t_d      = cnt_t_q + push_inc - pop_dec;
    cnt_c_d      = cnt_c_q - pop_dec;
    ovf_d        = ovf_q | push_drop;
    if (bus.flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      wr_cmt_ptr_d = '0;
      cnt_t_d      = '0;
      cnt_c_d      = '0;
      ovf_d        = 1'b0;
    end else if (discard) begin
      wr_ptr_d = wr_cmt_ptr_q;
      cnt_t_d  = cnt_c_q - pop_dec;
      cnt_c_d  = cnt_c_q - pop_dec;
      ovf_d    = 1'b0;
    end else if (bus.commit_i) begin
      wr_cmt_ptr_d = wr_ptr_d;
      cnt_c_d      = cnt_t_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      wr_cmt_ptr_q <= '0;
      cnt_c_q      <= '0;
      cnt_t_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_cmt_ptr_q <= wr_cmt_ptr_d;
      cnt_c_q      <= cnt_c_d;
      cnt_t_q      <= cnt_t_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage is written even under rollback; the pointer restore makes the word unreachable.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_i;
    end
  end

  assign bus.data_o     = mem_q[rd_ptr_q];
  assign bus.empty_o    = empty;
  assign bus.full_o     = full;
  assign bus.afull_o    = (cnt_t_q >= CNT_W'(AFULL_LEVEL));
  assign bus.overflow_o = ovf_q;
  assign bus.level_o    = cnt_c_q;
  assign bus.pending_o  = cnt_t_q - cnt_c_q;

  a_cnt_order: assert property (@(posedge clk_i) disable iff (rst_i)
    (cnt_c_q <= cnt_t_q) && (cnt_t_q <= CNT_W'(DEPTH)));
endmodule

// File: tb/tb_usbf_pkt_fifo.sv
// Directed bench for usbf_pkt_fifo: stimulus queues expected read words, a monitor checks each accepted pop.
module tb_usbf_pkt_fifo;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic clk_i;
  logic rst_i;
  int   n_chk;
  int   n_pass;
  logic [7:0] exp_q[$];

  usbf_pkt_fifo_if #(.WIDTH(8), .ADDR_W(6)) bus ();

  usbf_pkt_fifo #(
    .WIDTH(8), .DEPTH(64), .ADDR_W(6), .AFULL_LEVEL(56)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic chk_st(input string nm, input logic e, input logic f, input logic af,
                        input logic ov, input int lvl, input int pend);
    chk({nm, ".empty"},   32'(bus.empty_o),    32'(e));
    chk({nm, ".full"},    32'(bus.full_o),     32'(f));
    chk({nm, ".afull"},   32'(bus.afull_o),    32'(af));
    chk({nm, ".ovf"},     32'(bus.overflow_o), 32'(ov));
    chk({nm, ".level"},   32'(bus.level_o),    32'(lvl));
    chk({nm, ".pending"}, 32'(bus.pending_o),  32'(pend));
  endtask

  task automatic cyc(input logic ps, input logic [7:0] d, input logic pp,
                     input logic cm, input logic rb, input logic fl);
    bus.push_i     = ps;
    bus.data_i     = d;
    bus.pop_i      = pp;
    bus.commit_i   = cm;
    bus.rollback_i = rb;
    bus.flush_i    = fl;
    @(posedge clk_i);
    #1;
    bus.push_i     = N;
    bus.data_i     = 8'h00;
    bus.pop_i      = N;
    bus.commit_i   = N;
    bus.rollback_i = N;
    bus.flush_i    = N;
  endtask

  // Monitor: every pop the FIFO will accept at the next edge must present the oldest expected word.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && bus.pop_i && !bus.empty_o && !bus.flush_i) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL pop_data: got 0x%0h with no word expected", bus.data_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.data_o === e) n_pass++;
          else $display("FAIL pop_data: got 0x%0h want 0x%0h", bus.data_o, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    n_chk = 0;
    n_pass = 0;
    rst_i = 1'b1;
    bus.push_i = N; bus.data_i = 8'h00; bus.pop_i = N;
    bus.commit_i = N; bus.rollback_i = N; bus.flush_i = N;
    #2;
    chk_st("reset", Y, N, N, N, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Pending words stay invisible until commit.
    cyc(Y, 8'h11, N, N, N, N);
    cyc(Y, 8'h22, N, N, N, N);
    cyc(Y, 8'h33, N, N, N, N);
    chk_st("t1_pend", Y, N, N, N, 0, 3);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    cyc(N, 8'h00, N, Y, N, N);
    chk_st("t1_cmt", N, N, N, N, 3, 0);
    chk("t1_head", 32'(bus.data_o), 32'h11);
    for (int i = 0; i < 3; i++) cyc(N, 8'h00, Y, N, N, N);
    chk_st("t1_drain", Y, N, N, N, 0, 0);

    // Rollback with a same-cycle push; the next packet reuses the rollback point.
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    cyc(Y, 8'hA0, N, N, N, N);
    cyc(Y, 8'hA1, N, Y, N, N);
    cyc(Y, 8'hB0, N, N, N, N);
    cyc(Y, 8'hB1, N, N, N, N);
    cyc(Y, 8'hB2, N, N, N, N);
    chk_st("t2_pre", N, N, N, N, 2, 3);
    cyc(Y, 8'hFF, N, N, Y, N);
    chk_st("t2_rb", N, N, N, N, 2, 0);
    exp_q.push_back(8'hC0);
    cyc(Y, 8'hC0, N, Y, N, N);
    chk_st("t2_cmt", N, N, N, N, 3, 0);
    for (int i = 0; i < 3; i++) cyc(N, 8'h00, Y, N, N, N);
    chk_st("t2_drain", Y, N, N, N, 0, 0);

    // Fill to full, overflow, then a commit acts as rollback.
    for (int i = 0; i < 64; i++) begin
      cyc(Y, 8'(i), N, N, N, N);
      if (i == 54) chk("t3_afull55", 32'(bus.afull_o), 32'd0);
      if (i == 55) chk("t3_afull56", 32'(bus.afull_o), 32'd1);
      if (i == 62) chk("t3_full63", 32'(bus.full_o), 32'd0);
    end
    chk_st("t3_full", Y, Y, Y, N, 0, 64);
    cyc(Y, 8'hEE, N, N, N, N);
    chk_st("t3_ovf", Y, Y, Y, Y, 0, 64);
    cyc(N, 8'h00, N, Y, N, N);
    chk_st("t3_cmt", Y, N, N, N, 0, 0);

    // Three 50-word packets, crossing the 63->0 pointer wrap.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 50; i++) begin
        d = 8'(p * 50 + i + 1);
        exp_q.push_back(d);
        cyc(Y, d, N, (i == 49) ? Y : N, N, N);
      end
      chk_st($sformatf("t4_pkt%0d", p), N, N, N, N, 50, 0);
      for (int i = 0; i < 50; i++) cyc(N, 8'h00, Y, N, N, N);
      chk_st($sformatf("t4_drain%0d", p), Y, N, N, N, 0, 0);
    end

    // Pop alongside commit+push, then flush with push+pop asserted.
    for (int i = 0; i < 5; i++) begin
      d = 8'hD0 + 8'(i);
      exp_q.push_back(d);
      cyc(Y, d, N, (i == 4) ? Y : N, N, N);
    end
    cyc(Y, 8'hE0, N, N, N, N);
    cyc(Y, 8'hE1, N, N, N, N);
    chk_st("t5_pre", N, N, N, N, 5, 2);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE1); exp_q.push_back(8'hE2);
    cyc(Y, 8'hE2, Y, Y, N, N);
    chk_st("t5_cmt", N, N, N, N, 7, 0);
    exp_q.delete();
    cyc(Y, 8'h77, Y, N, N, Y);
    chk_st("t5_flush", Y, N, N, N, 0, 0);

    // Build level 4 / pending 3 / overflow, then reset asynchronously mid-cycle.
    for (int i = 0; i < 61; i++) begin
      exp_q.push_back(8'(i));
      cyc(Y, 8'(i), N, (i == 60) ? Y : N, N, N);
    end
    for (int i = 0; i < 3; i++) cyc(Y, 8'h80 + 8'(i), N, N, N, N);
    cyc(Y, 8'hEE, N, N, N, N);
    chk_st("t6_ovf", N, Y, Y, Y, 61, 3);
    for (int i = 0; i < 57; i++) cyc(N, 8'h00, Y, N, N, N);
    chk_st("t6_pre", N, N, N, Y, 4, 3);
    #2;
    rst_i = 1'b1;
    #1;
    chk_st("t6_arst", Y, N, N, N, 0, 0);
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    exp_q.push_back(8'h5A);
    cyc(Y, 8'h5A, N, Y, N, N);
    chk_st("t6_post", N, N, N, N, 1, 0);
    cyc(N, 8'h00, Y, N, N, N);
    chk_st("t6_drain", Y, N, N, N, 0, 0);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/usbf_pkt_fifo.md
Name: usbf_pkt_fifo

Overview:
Parametrised packet FIFO, successor to the endpoint byte FIFO, for USB endpoint receive/transmit buffering. Writes are staged as "pending" and become visible to the reader only on commit_i; rollback_i discards the pending packet (CRC error, NAK, retry). It provides committed level, pending count, almost-full and a sticky overflow flag. An overflowed packet cannot be committed.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 64, storage entries; must equal 2**ADDR_W
ADDR_W, 6, pointer width
AFULL_LEVEL, 56, almost-full threshold on total occupancy (committed + pending), 1..DEPTH

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
data_i  in  WIDTH  write data
push_i  in  1  write request
commit_i  in  1  publish all pending words (including a push in the same cycle)
rollback_i  in  1  discard all pending words
pop_i  in  1  read request (advance read pointer)
flush_i  in  1  synchronous clear of entire FIFO
data_o  out  WIDTH  word at read pointer (combinational from RAM)
empty_o  out  1  no committed words
full_o  out  1  total occupancy == DEPTH
afull_o  out  1  total occupancy >= AFULL_LEVEL
overflow_o  out  1  sticky: push dropped while full during current packet
level_o  out  ADDR_W+1  committed word count
pending_o  out  ADDR_W+1  uncommitted word count

Behaviour:
- State: rd_ptr, wr_ptr, wr_commit_ptr (ADDR_W, wrap modulo DEPTH); cnt_c (committed) and cnt_t (total), both ADDR_W+1 bits; ovf flag. Counts never wrap.
- Reset (async): all pointers, counts and ovf are 0. Outputs: empty_o=1, full_o=0, afull_o=0, overflow_o=0, level_o=0, pending_o=0. RAM is not reset; data_o is undefined while empty.
- push_ok = push_i & ~full_o & ~flush_i. pop_ok = pop_i & ~empty_o & ~flush_i.
- push_i while full: word dropped, ovf<=1. No pointer or count change.
- push_ok: ram[wr_ptr]<=data_i; wr_ptr+1. RAM write occurs even if rollback_i is asserted; the word is discarded by the pointer restore.
- pop_ok: rd_ptr+1. data_o shows the next word the following cycle (zero-latency read; data_o is valid whenever empty_o=0).
- Priority per cycle: flush > rollback > commit.
- flush_i: all pointers, counts and ovf are 0 next cycle. Push, pop, commit and rollback are ignored that cycle.
- rollback_i (no flush): wr_ptr<=wr_commit_ptr; cnt_t<=cnt_c-pop_ok; ovf<=0. Same-cycle push is discarded. Same-cycle commit is ignored.
- commit_i, no rollback, ovf=0 and no overflowing push this cycle: wr_commit_ptr<=wr_ptr+push_ok; cnt_c<=cnt_t+push_ok-pop_ok; cnt_t<=cnt_t+push_ok-pop_ok.
- commit_i while ovf=1, or while a push is dropped this cycle: treated exactly as rollback (packet discarded, ovf cleared).
- Otherwise: cnt_t<=cnt_t+push_ok-pop_ok; cnt_c<=cnt_c-pop_ok.
- Outputs:
  - empty_o=(cnt_c==0)
  - full_o=(cnt_t==DEPTH)
  - afull_o=(cnt_t>=AFULL_LEVEL)
  - level_o=cnt_c
  - pending_o=cnt_t-cnt_c
  - overflow_o=ovf
- Simultaneous push+pop at full: push rejected (full is evaluated before the pop). Simultaneous push+pop at empty: pop rejected. A pushed word becomes poppable only in the cycle after its commit.
- Pointer wrap: DEPTH is a power of two; natural ADDR_W overflow wraps 63->0.
- Invariant for verification: 0 <= cnt_c <= cnt_t <= DEPTH at all times.

Test Plan:
- Reset, then push 0x11,0x22,0x33 without commit -> empty_o=1, pending_o=3, level_o=0. Commit -> next cycle empty_o=0, level_o=3, pending_o=0, data_o=0x11. Three pops return 0x11,0x22,0x33, then empty_o=1.
- Commit 2 words (0xA0,0xA1), push 3 more, assert rollback_i with a push of 0xFF the same cycle -> level_o=2, pending_o=0. Pops return 0xA0,0xA1 only; the next committed packet starts at the former rollback point.
- Push 64 words -> full_o=1, afull_o=1 from the 56th push. Push a 65th -> overflow_o=1, counts unchanged. Commit -> behaves as rollback: level_o=0, pending_o=0, overflow_o=0, empty_o=1.
- Wrap: 50 words in/out repeatedly over 3 packets crossing address 63->0 -> data order preserved, counts exact.
- Simultaneous pop and commit+push with level_o=5, pending_o=2 -> next cycle level_o=7, pending_o=0. Flush with push+pop asserted -> all counts 0, empty_o=1.
- Assert rst_i asynchronously mid-packet (level 4, pending 3, ovf=1) -> outputs return to reset values immediately, without waiting for a clock edge.
